// File: rtl/nn_decision_pkg.sv
// Shared types and default sizing for the nn_decision block.
package nn_decision_pkg;
    localparam int DEF_OUT_SIZE   = 3;
    localparam int DEF_PROB_W     = 256;
    localparam int DEF_STABLE_CNT = 3;
    localparam int STATS_W        = 16;

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;
endpackage

// File: rtl/nn_decision_if.sv
// Score-frame handshake bus from top_nn into nn_decision.
interface nn_decision_if
    import nn_decision_pkg::*;
#(
    parameter int OUT_SIZE = DEF_OUT_SIZE,
    parameter int PROB_W   = DEF_PROB_W
);
    logic              prob_valid;
    logic              prob_ready;
    logic [PROB_W-1:0] prob_data [0:OUT_SIZE-1];
    logic [PROB_W-1:0] min_margin;

    modport master (output prob_valid, prob_data, min_margin, input prob_ready);
    modport slave  (input prob_valid, prob_data, min_margin, output prob_ready);
endinterface

// File: rtl/nn_decision_debounce.sv
// Winner debounce: tracks the last accepted winner and how many frames in a
// row it has won, and pulses class_valid when the streak first reaches
// STABLE_CNT.
module nn_decision_debounce
    import nn_decision_pkg::*;
#(
    parameter int OUT_SIZE   = DEF_OUT_SIZE,
    parameter int PROB_W     = DEF_PROB_W,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int IDX_W      = $clog2(OUT_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              decide,
    input  logic              reject,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [PROB_W-1:0] best,
    output logic              class_valid,
    output logic [IDX_W-1:0]  class_id,
    output logic [PROB_W-1:0] class_score
);
    localparam int STREAK_W = $clog2(STABLE_CNT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STABLE_CNT);

    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_nxt;
    logic [IDX_W-1:0]    last_cand;
    logic                new_win;
    logic                fire;

    // Next streak value and whether this frame completes a stable decision.
    always_comb begin
        new_win    = (best_idx != last_cand) || (streak == '0);
        streak_nxt = streak;
        fire       = 1'b0;
        if (reject) begin
            streak_nxt = '0;
        end else if (new_win) begin
            streak_nxt = STREAK_W'(1);
            fire       = (STABLE_CNT == 1);
        end else begin
            streak_nxt = (streak == STREAK_MAX) ? streak : streak + 1'b1;
            fire       = (streak != STREAK_MAX) && (streak_nxt == STREAK_MAX);
        end
    end

    // Streak state and the registered decision outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak      <= '0;
            last_cand   <= '0;
            class_valid <= 1'b0;
            class_id    <= '0;
            class_score <= '0;
        end else begin
            class_valid <= 1'b0;
            if (decide) begin
                streak <= streak_nxt;
                if (!reject && new_win)
                    last_cand <= best_idx;
                if (fire) begin
                    class_valid <= 1'b1;
                    class_id    <= best_idx;
                    class_score <= best;
                end
            end
        end
    end
endmodule

// File: rtl/nn_decision.sv
// nn_decision: captures a score frame, serially scans for best/second-best,
// applies a margin test and debounces the winner across frames.
// Optional per-class decision counters: define NN_DECISION_STATS_EN.
module nn_decision
    import nn_decision_pkg::*;
#(
    parameter int OUT_SIZE   = DEF_OUT_SIZE,
    parameter int PROB_W     = DEF_PROB_W,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int IDX_W      = $clog2(OUT_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    nn_decision_if.slave       bus,
    output logic               frame_done,
    output logic               frame_reject,
    output logic [IDX_W-1:0]   raw_id,
    output logic               class_valid,
    output logic [IDX_W-1:0]   class_id,
    output logic [PROB_W-1:0]  class_score,
    output logic [STATS_W-1:0] stats_count [0:OUT_SIZE-1]
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);

    state_t            state;
    logic              ready;
    logic [PROB_W-1:0] s [0:OUT_SIZE-1];
    logic [PROB_W-1:0] mm;
    logic [IDX_W-1:0]  idx;
    logic [PROB_W-1:0] best;
    logic [PROB_W-1:0] second;
    logic [IDX_W-1:0]  best_idx;
    logic              decide;
    logic              reject;

    assign bus.prob_ready = ready;
    assign decide = (state == DECIDE);
    // best >= second always holds, so the plain subtraction cannot wrap.
    assign reject = (best - second) < mm;

    // Capture / scan / decide sequencer with registered frame outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ready        <= 1'b1;
            mm           <= '0;
            idx          <= '0;
            best         <= '0;
            second       <= '0;
            best_idx     <= '0;
            frame_done   <= 1'b0;
            frame_reject <= 1'b0;
            raw_id       <= '0;
            for (int k = 0; k < OUT_SIZE; k++) s[k] <= '0;
        end else begin
            frame_done   <= 1'b0;
            frame_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.prob_valid && ready) begin
                        s     <= bus.prob_data;
                        mm    <= bus.min_margin;
                        idx   <= '0;
                        ready <= 1'b0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lower index on ties.
                    if (idx == '0) begin
                        best     <= s[0];
                        best_idx <= '0;
                        second   <= '0;
                    end else if (s[idx] > best) begin
                        second   <= best;
                        best     <= s[idx];
                        best_idx <= idx;
                    end else if (s[idx] > second) begin
                        second   <= s[idx];
                    end
                    if (idx == LAST_IDX) state <= DECIDE;
                    else                 idx   <= idx + 1'b1;
                end
                DECIDE: begin
                    frame_done   <= 1'b1;
                    frame_reject <= reject;
                    raw_id       <= best_idx;
                    ready        <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    nn_decision_debounce #(
        .OUT_SIZE  (OUT_SIZE),
        .PROB_W    (PROB_W),
        .STABLE_CNT(STABLE_CNT),
        .IDX_W     (IDX_W)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .decide     (decide),
        .reject     (reject),
        .best_idx   (best_idx),
        .best       (best),
        .class_valid(class_valid),
        .class_id   (class_id),
        .class_score(class_score)
    );

`ifdef NN_DECISION_STATS_EN
    // Saturating per-class count of stable decisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < OUT_SIZE; k++) stats_count[k] <= '0;
        end else if (class_valid) begin
            for (int k = 0; k < OUT_SIZE; k++)
                if (class_id == IDX_W'(k) && stats_count[k] != '1)
                    stats_count[k] <= stats_count[k] + 1'b1;
        end
    end
`else
    for (genvar k = 0; k < OUT_SIZE; k++) begin : g_no_stats
        assign stats_count[k] = '0;
    end
`endif
endmodule

// File: tb/tb_nn_decision.sv
// Directed bench for nn_decision at default sizing (3 classes, 256-bit, 3-frame debounce).
module tb_nn_decision;
    import nn_decision_pkg::*;

    localparam int N  = 3;
    localparam int PW = 256;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nn_decision_if #(.OUT_SIZE(N), .PROB_W(PW)) bus ();

    logic          frame_done, frame_reject, class_valid;
    logic [IW-1:0] raw_id, class_id;
    logic [PW-1:0] class_score;
    logic [15:0]   stats_count [0:N-1];

    nn_decision dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_done  (frame_done),
        .frame_reject(frame_reject),
        .raw_id      (raw_id),
        .class_valid (class_valid),
        .class_id    (class_id),
        .class_score (class_score),
        .stats_count (stats_count)
    );

    int errors = 0;
    int checks = 0;

    logic          r_rej, r_cv;
    logic [IW-1:0] r_raw;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one frame at a negedge, then sample the frame outputs when
    // frame_done shows up; latency is counted in negedge samples.
    task automatic run_frame(input string tag, input logic [PW-1:0] a, input logic [PW-1:0] b,
                             input logic [PW-1:0] c, input logic [PW-1:0] m);
        int n;
        n = 0;
        while (!bus.prob_ready && n < 50) begin @(negedge clk); n++; end
        bus.prob_valid    = 1'b1;
        bus.prob_data[0]  = a;
        bus.prob_data[1]  = b;
        bus.prob_data[2]  = c;
        bus.min_margin    = m;
        @(negedge clk);
        bus.prob_valid    = 1'b0;
        bus.prob_data[0]  = '0;
        bus.prob_data[1]  = '0;
        bus.prob_data[2]  = '0;
        n = 1;
        while (!frame_done && n < 20) begin @(negedge clk); n++; end
        check({tag, " latency"}, PW'(n), PW'(5));
        r_rej = frame_reject;
        r_raw = raw_id;
        r_cv  = class_valid;
    endtask

    logic [PW-1:0] full, half;
    int hs, cvn, last, cnt;

    initial begin
        full = '1;
        half = '0;
        half[PW-1] = 1'b1;
        rst = 1'b1;
        bus.prob_valid = 1'b0;
        bus.min_margin = '0;
        for (int k = 0; k < N; k++) bus.prob_data[k] = '0;
        repeat (2) @(negedge clk);

        check("rst ready", bus.prob_ready, 1);
        check("rst done", frame_done, 0);
        check("rst reject", frame_reject, 0);
        check("rst raw_id", raw_id, 0);
        check("rst class_valid", class_valid, 0);
        check("rst class_score", class_score, 0);
        check("rst stats1", stats_count[1], 0);
        rst = 1'b0;
        @(negedge clk);

        // Two accepted class-1 frames, then a reset during the third scan.
        run_frame("a1", 10, 50, 20, 0);
        check("a1 raw_id", r_raw, 1);
        check("a1 reject", r_rej, 0);
        check("a1 class_valid", r_cv, 0);
        run_frame("a2", 10, 50, 20, 0);
        check("a2 class_valid", r_cv, 0);

        bus.prob_valid   = 1'b1;
        bus.prob_data[0] = 10;
        bus.prob_data[1] = 50;
        bus.prob_data[2] = 20;
        @(posedge clk);
        #1 bus.prob_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid rst ready", bus.prob_ready, 1);
        check("mid rst done", frame_done, 0);
        check("mid rst raw_id", raw_id, 0);
        check("mid rst class_id", class_id, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (frame_done) cnt++; end
        check("mid rst no done", PW'(cnt), 0);

        // Streak restarted: pulse only on the third accepted frame.
        run_frame("c1", 10, 50, 20, 25);
        check("c1 class_valid", r_cv, 0);
        run_frame("c2", 10, 50, 20, 25);
        check("c2 class_valid", r_cv, 0);
        run_frame("c3", 10, 50, 20, 25);
        check("c3 class_valid", r_cv, 1);
        check("c3 class_id", class_id, 1);
        check("c3 class_score", class_score, 50);
        run_frame("c4", 10, 50, 20, 25);
        check("c4 class_valid", r_cv, 0);

        // Reject breaks the streak.
        run_frame("d0", 40, 45, 0, 10);
        check("d0 reject", r_rej, 1);
        check("d0 raw_id", r_raw, 1);
        check("d0 class_valid", r_cv, 0);
        check("d0 class_id held", class_id, 1);
        run_frame("d1", 10, 50, 20, 10);
        check("d1 class_valid", r_cv, 0);
        run_frame("d2", 10, 50, 20, 10);
        check("d2 class_valid", r_cv, 0);
        run_frame("d3", 10, 50, 20, 10);
        check("d3 class_valid", r_cv, 1);

        // Ties, full-scale margin, equal scores, margin boundary.
        run_frame("tie", 30, 30, 5, 0);
        check("tie raw_id", r_raw, 0);
        check("tie reject", r_rej, 0);
        run_frame("max", 0, 0, full, half);
        check("max raw_id", r_raw, 2);
        check("max reject", r_rej, 0);
        run_frame("maxeq", 0, 0, full, full);
        check("maxeq reject", r_rej, 0);
        run_frame("eq", 7, 7, 7, 1);
        check("eq reject", r_rej, 1);
        check("eq raw_id", r_raw, 0);
        run_frame("eq0", 7, 7, 7, 0);
        check("eq0 reject", r_rej, 0);
        run_frame("bnd", 0, 20, 10, 10);
        check("bnd reject", r_rej, 0);
        run_frame("bnd1", 0, 20, 10, 11);
        check("bnd1 reject", r_rej, 1);
        check("bnd1 class_valid", r_cv, 0);

        // prob_valid held high: handshakes every 5 cycles, one class-2 decision.
        bus.prob_valid   = 1'b1;
        bus.prob_data[0] = 0;
        bus.prob_data[1] = 0;
        bus.prob_data[2] = 100;
        bus.min_margin   = 0;
        hs = 0; cvn = 0; last = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.prob_ready) begin
                if (last >= 0) check("b2b gap", PW'(i - last), 5);
                last = i;
                hs++;
            end
            if (class_valid) cvn++;
            @(negedge clk);
        end
        bus.prob_valid = 1'b0;
        if (class_valid) cvn++;
        check("b2b handshakes", PW'(hs), 4);
        check("b2b pulses", PW'(cvn), 1);
        check("b2b class_id", class_id, 2);
        check("b2b class_score", class_score, 100);

        repeat (3) @(negedge clk);
`ifdef NN_DECISION_STATS_EN
        check("stats0", stats_count[0], 0);
        check("stats1", stats_count[1], 2);
        check("stats2", stats_count[2], 1);
`else
        check("stats0", stats_count[0], 0);
        check("stats1", stats_count[1], 0);
        check("stats2", stats_count[2], 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
